// File: rtl/rvfi_retire_buffer.sv
// ============================================================================
// Module   : rvfi_retire_buffer
// Function : Multi-channel RVFI retirement trace buffer. Compacts up to NRET
//            retirements per cycle into a DEPTH-entry FIFO (all-or-nothing on
//            overflow), checks retirement-order contiguity, and presents the
//            head record first-word-fall-through on a valid/ready port.
// Options  : RVFI_RETIRE_BUFFER_TS_EN - store a free-running 32-bit cycle
//            timestamp with each record and present it on out_ts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvfi_retire_buffer #(
    parameter  int NRET    = 2,
    parameter  int XLEN    = 32,
    parameter  int DEPTH   = 16,
    localparam int REC_W   = 114 + 8*XLEN + XLEN/4,
    localparam int C_LVL_W = $clog2(DEPTH+1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*REC_W-1:0]   rvfi_rec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [REC_W-1:0]        out_rec,
    output logic [31:0]             out_ts,
    output logic [C_LVL_W-1:0]      level,
    output logic                    overflow,
    output logic                    order_err,
    output logic [15:0]             drop_cnt,
    input  logic                    clear
);

    localparam int C_PTR_W = $clog2(DEPTH);

    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;
    logic [C_LVL_W-1:0] r_level;
    logic [63:0]        r_exp;
    logic               r_overflow;
    logic               r_order_err;
    logic [15:0]        r_drop_cnt;
    logic [REC_W-1:0]   r_mem [DEPTH];

    logic [C_LVL_W-1:0] w_num;
    logic [C_LVL_W-1:0] w_free;
    logic               w_ovf;
    logic               w_pop;
    logic               w_order_bad;
    logic [63:0]        w_last_order;
    logic [C_PTR_W-1:0] w_slot [NRET];
    logic [16:0]        w_drop_sum;

    // Compact valid channels onto consecutive tail slots and check each order
    // against the expected value offset by its compacted position.
    always_comb begin
        w_num        = '0;
        w_order_bad  = 1'b0;
        w_last_order = r_exp;
        for (int k = 0; k < NRET; k++) begin
            w_slot[k] = r_tail + w_num[C_PTR_W-1:0];
            if (rvfi_valid[k]) begin
                if (rvfi_rec[k*REC_W + REC_W - 64 +: 64] != r_exp + 64'(w_num)) begin
                    w_order_bad = 1'b1;
                end
                w_last_order = rvfi_rec[k*REC_W + REC_W - 64 +: 64];
                w_num        = w_num + C_LVL_W'(1);
            end
        end
    end

    // Free space is judged against the pre-pop level, so a pop never makes room
    // for a write in the same cycle.
    assign w_free     = C_LVL_W'(DEPTH) - r_level;
    assign w_ovf      = (w_num > w_free);
    assign w_pop      = (r_level != '0) && out_ready;
    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_num);

    // Pointer, occupancy and expected-order bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
            r_exp   <= '0;
        end else begin
            if (!w_ovf) begin
                r_tail <= r_tail + w_num[C_PTR_W-1:0];
            end
            if (w_pop) begin
                r_head <= r_head + C_PTR_W'(1);
            end
            r_level <= r_level + (w_ovf ? '0 : w_num) - C_LVL_W'(w_pop);
            if (w_num != '0) begin
                r_exp <= w_last_order + 64'd1;
            end
        end
    end

    // Sticky status; a same-cycle event overrides clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_order_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (clear) begin
                r_overflow  <= 1'b0;
                r_order_err <= 1'b0;
                r_drop_cnt  <= '0;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
                if (clear) begin
                    r_drop_cnt <= 16'(w_num);
                end else begin
                    r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
                end
            end
            if (w_order_bad) begin
                r_order_err <= 1'b1;
            end
        end
    end

    // Record storage; unreset because the outputs are masked while empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NRET; k++) begin
            if (!w_ovf && rvfi_valid[k]) begin
                r_mem[w_slot[k]] <= rvfi_rec[k*REC_W +: REC_W];
            end
        end
    end

`ifdef RVFI_RETIRE_BUFFER_TS_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_ts_mem [DEPTH];

    // Free-running cycle counter, wraps at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ts_cnt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
        end
    end

    // All records written in one cycle share the current counter value.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NRET; k++) begin
            if (!w_ovf && rvfi_valid[k]) begin
                r_ts_mem[w_slot[k]] <= r_ts_cnt;
            end
        end
    end

    assign out_ts = out_valid ? r_ts_mem[r_head] : 32'h0;
`else
    assign out_ts = 32'h0;
`endif

    assign out_valid = (r_level != '0);
    assign out_rec   = out_valid ? r_mem[r_head] : '0;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign order_err = r_order_err;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rvfi_retire_buffer.sv
// ============================================================================
// Module   : tb_rvfi_retire_buffer
// Function : Self-checking bench for rvfi_retire_buffer: directed scenarios
//            with literal expectations plus randomized traffic compared every
//            cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvfi_retire_buffer;

    localparam int NRET  = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int REC_W = 114 + 8*XLEN + XLEN/4;
    localparam int LVL_W = $clog2(DEPTH+1);

    logic                  clk;
    logic                  resetn;
    logic [NRET-1:0]       rvfi_valid;
    logic [NRET*REC_W-1:0] rvfi_rec;
    logic                  out_valid;
    logic                  out_ready;
    logic [REC_W-1:0]      out_rec;
    logic [31:0]           out_ts;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic                  order_err;
    logic [15:0]           drop_cnt;
    logic                  clear;

    int checks = 0;
    int errors = 0;

    rvfi_retire_buffer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rvfi_valid (rvfi_valid),
        .rvfi_rec   (rvfi_rec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rec    (out_rec),
        .out_ts     (out_ts),
        .level      (level),
        .overflow   (overflow),
        .order_err  (order_err),
        .drop_cnt   (drop_cnt),
        .clear      (clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [REC_W-1:0] m_q[$];
    logic [31:0]      m_tsq[$];
    logic [63:0]      m_exp = '0;
    logic [31:0]      m_ts  = '0;
    logic             m_ovf = 1'b0;
    logic             m_err = 1'b0;
    int               m_drop = 0;

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_q.delete();
                m_tsq.delete();
                m_exp = '0; m_ts = '0; m_ovf = 1'b0; m_err = 1'b0; m_drop = 0;
            end else begin
                int          num;
                logic        bad;
                logic        pop;
                logic [63:0] ord;
                logic [63:0] last;
                num = 0; bad = 1'b0; last = '0;
                for (int k = 0; k < NRET; k++) begin
                    if (rvfi_valid[k]) begin
                        ord = rvfi_rec[k*REC_W + REC_W - 64 +: 64];
                        if (ord != m_exp + 64'(num)) bad = 1'b1;
                        last = ord;
                        num++;
                    end
                end
                pop = (m_q.size() != 0) && out_ready;
                if (num > DEPTH - m_q.size()) begin
                    if (clear) m_drop = 0;
                    m_ovf  = 1'b1;
                    m_drop = (m_drop + num > 65535) ? 65535 : m_drop + num;
                end else begin
                    if (clear) begin m_ovf = 1'b0; m_drop = 0; end
                    for (int k = 0; k < NRET; k++) begin
                        if (rvfi_valid[k]) begin
                            m_q.push_back(rvfi_rec[k*REC_W +: REC_W]);
                            m_tsq.push_back(m_ts);
                        end
                    end
                end
                if (pop) begin
                    void'(m_q.pop_front());
                    void'(m_tsq.pop_front());
                end
                if (clear) m_err = 1'b0;
                if (bad) m_err = 1'b1;
                if (num > 0) m_exp = last + 64'd1;
                m_ts = m_ts + 32'd1;
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic [REC_W-1:0] e_rec;
                logic [31:0]      e_ts;
                e_rec = '0;
                e_ts  = '0;
                if (m_q.size() != 0) begin
                    e_rec = m_q[0];
`ifdef RVFI_RETIRE_BUFFER_TS_EN
                    e_ts  = m_tsq[0];
`endif
                end
                chk("m_out_valid", REC_W'(out_valid), REC_W'(m_q.size() != 0));
                chk("m_level",     REC_W'(level),     REC_W'(m_q.size()));
                chk("m_out_rec",   out_rec,           e_rec);
                chk("m_out_ts",    REC_W'(out_ts),    REC_W'(e_ts));
                chk("m_overflow",  REC_W'(overflow),  REC_W'(m_ovf));
                chk("m_order_err", REC_W'(order_err), REC_W'(m_err));
                chk("m_drop_cnt",  REC_W'(drop_cnt),  REC_W'(m_drop));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [REC_W-1:0] mkrec(input logic [63:0] ord);
        logic [383:0]     t;
        logic [REC_W-1:0] r;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        r = t[REC_W-1:0];
        r[REC_W-1 -: 64] = ord;
        return r;
    endfunction

    task automatic drive(input logic [NRET-1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic rdy, input logic clr);
        rvfi_valid = v;
        rvfi_rec   = {mkrec(o1), mkrec(o0)};
        out_ready  = rdy;
        clear      = clr;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] head_ord();
        return out_rec[REC_W-1 -: 64];
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] n;
        resetn = 1'b0;
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", REC_W'(out_valid), '0);
        chk("rst_level",     REC_W'(level),     '0);
        chk("rst_out_rec",   out_rec,           '0);
        resetn = 1'b1;

        // single channel, back-to-back, drained every cycle
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 64'(i), 0, 1'b1, 1'b0);
            cycle();
            chk("s1_valid", REC_W'(out_valid), REC_W'(1));
            chk("s1_order", REC_W'(head_ord()), REC_W'(i));
            chk("s1_level", REC_W'(level), REC_W'(1));
        end
        drive(2'b00, 0, 0, 1'b1, 1'b0);
        cycle();
        chk("s1_empty", REC_W'(out_valid), '0);

        // two channels then channel 1 alone: 4,5,6 in order
        drive(2'b11, 4, 5, 1'b1, 1'b0);
        cycle();
        chk("s2_head4", REC_W'(head_ord()), REC_W'(4));
        chk("s2_lvl2",  REC_W'(level), REC_W'(2));
        drive(2'b10, 0, 6, 1'b1, 1'b0);
        cycle();
        chk("s2_head5", REC_W'(head_ord()), REC_W'(5));
        drive(2'b00, 0, 0, 1'b1, 1'b0);
        cycle();
        chk("s2_head6", REC_W'(head_ord()), REC_W'(6));
        cycle();
        chk("s2_order_err", REC_W'(order_err), '0);

        // order discontinuity with E=7, then resync to 10 alongside clear
        drive(2'b01, 9, 0, 1'b1, 1'b0);
        cycle();
        chk("s4_err_set", REC_W'(order_err), REC_W'(1));
        drive(2'b01, 10, 0, 1'b1, 1'b1);
        cycle();
        chk("s4_resync", REC_W'(order_err), '0);
        drive(2'b00, 0, 0, 1'b1, 1'b0);
        cycle();

        // fill to 16, then an all-or-nothing overflow of two records
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 64'(11 + 2*i), 64'(12 + 2*i), 1'b0, 1'b0);
            cycle();
        end
        chk("s3_full", REC_W'(level), REC_W'(16));
        drive(2'b11, 27, 28, 1'b0, 1'b0);
        cycle();
        chk("s3_ovf",   REC_W'(overflow), REC_W'(1));
        chk("s3_drop",  REC_W'(drop_cnt), REC_W'(2));
        chk("s3_level", REC_W'(level), REC_W'(16));
        chk("s3_head",  REC_W'(head_ord()), REC_W'(11));
        drive(2'b00, 0, 0, 1'b0, 1'b1);
        cycle();
        chk("s3_clr_ovf",  REC_W'(overflow), '0);
        chk("s3_clr_drop", REC_W'(drop_cnt), '0);
        chk("s3_clr_lvl",  REC_W'(level), REC_W'(16));

        // drop counter saturation
        for (int i = 0; i < 32768; i++) begin
            drive(2'b11, 64'(29 + 2*i), 64'(30 + 2*i), 1'b0, 1'b0);
            cycle();
        end
        chk("sat_drop", REC_W'(drop_cnt), REC_W'(16'hFFFF));
        chk("sat_err",  REC_W'(order_err), '0);

        // drain to 5 then asynchronous reset between edges
        drive(2'b00, 0, 0, 1'b1, 1'b0);
        repeat (11) cycle();
        chk("s5_level5", REC_W'(level), REC_W'(5));
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        resetn = 1'b0;
        #2;
        chk("s5_async_valid", REC_W'(out_valid), '0);
        chk("s5_async_level", REC_W'(level), '0);
        chk("s5_async_drop",  REC_W'(drop_cnt), '0);
        chk("s5_async_ovf",   REC_W'(overflow), '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // timestamp of a record written when the counter reads 100
        repeat (100) cycle();
        drive(2'b01, 0, 0, 1'b0, 1'b0);
        cycle();
`ifdef RVFI_RETIRE_BUFFER_TS_EN
        chk("ts_100", REC_W'(out_ts), REC_W'(100));
`else
        chk("ts_off", REC_W'(out_ts), '0);
`endif
        chk("ts_order", REC_W'(head_ord()), '0);

        // randomized traffic against the model
        n = 64'd1;
        for (int c = 0; c < 3000; c++) begin
            logic [NRET-1:0] v;
            logic [63:0]     o0;
            logic [63:0]     o1;
            v  = NRET'($urandom_range(0, 3));
            o0 = n;
            o1 = v[0] ? n + 64'd1 : n;
            if ($urandom_range(0, 15) == 0) o0 = o0 + 64'($urandom_range(1, 5));
            if ($urandom_range(0, 15) == 0) o1 = o1 + 64'($urandom_range(1, 5));
            if (v[1])      n = o1 + 64'd1;
            else if (v[0]) n = o0 + 64'd1;
            drive(v, o0, o1, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            cycle();
        end

        drive(2'b00, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
